// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED cross-fade stage.
package led_fader_pkg;

  typedef enum logic [0:0] {IDLE, FADING} state_t;

  // Full-on brightness code for a given PWM resolution.
  function automatic int unsigned max_level(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED: brightness level ramping toward an on/off target, plus the PWM compare.
module led_fade_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_tick,
  input  logic                load,
  input  logic                target_on,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                at_target,
  output logic                led
);

  localparam int unsigned MAX = max_level(PWM_BITS);
  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] target;

  assign at_target = (level == target);

  // Level steps use the old target; a load only ever coincides with level==target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level  <= '0;
      target <= '0;
      led    <= 1'b0;
    end else begin
      if (step_tick) begin
        if (level < target)      level <= level + LVL_ONE;
        else if (level > target) level <= level - LVL_ONE;
      end
      if (load) target <= target_on ? LVL_MAX : '0;
      led <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fader.sv
// Pattern sink driving 8 PWM LEDs with linear cross-fades and a one-entry pending buffer.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS         = 8,
  parameter int unsigned PERIODS_PER_STEP = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pat_valid,
  input  logic [7:0] pat_data,
  output logic       pat_ready,
  output logic [7:0] led,
  output logic       busy
);

  localparam int unsigned NUM_LEDS = 8;
  localparam int unsigned MAX      = max_level(PWM_BITS);
  localparam int unsigned PER_W    = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX - 1);
  localparam logic [PER_W-1:0]    PER_LAST = PER_W'(PERIODS_PER_STEP - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PER_W-1:0]    per_cnt;
  logic                pwm_wrap;
  logic                step_tick;

  state_t              state;
  logic [7:0]          pending;
  logic                pending_valid;
  logic                transfer;
  logic                fading;
  logic                all_at_target;
  logic [NUM_LEDS-1:0] at_target;
  logic                load_c;
  logic [7:0]          load_data_c;

  assign pwm_wrap      = (pwm_cnt == PWM_LAST);
  assign step_tick     = pwm_wrap && (per_cnt == PER_LAST);
  assign pat_ready     = !pending_valid;
  assign transfer      = pat_valid && pat_ready;
  assign fading        = (state == FADING);
  assign all_at_target = &at_target;
  assign busy          = fading || pending_valid;

  // Free-running PWM and step counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      per_cnt <= '0;
    end else if (pwm_wrap) begin
      pwm_cnt <= '0;
      per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // New targets: on an IDLE transfer, or at fade completion (pending first, then live data).
  always_comb begin
    load_c      = 1'b0;
    load_data_c = pat_data;
    if (!fading) begin
      load_c = transfer;
    end else if (all_at_target) begin
      if (pending_valid) begin
        load_c      = 1'b1;
        load_data_c = pending;
      end else begin
        load_c = transfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) state <= FADING;
        end
        FADING: begin
          if (all_at_target) begin
            if (pending_valid)  pending_valid <= 1'b0;
            else if (!transfer) state <= IDLE;
          end else if (transfer) begin
            pending       <= pat_data;
            pending_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_tick(step_tick && fading),
      .load     (load_c),
      .target_on(load_data_c[i]),
      .pwm_cnt  (pwm_cnt),
      .at_target(at_target[i]),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader at PWM_BITS=3, PERIODS_PER_STEP=2 against an arithmetic reference model.
module tb_led_fader;

  localparam int MAXL = 7;
  localparam int PER  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pat_valid;
  logic [7:0] pat_data;
  logic       pat_ready;
  logic [7:0] led;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycle phase, per-LED brightness and targets, pending slot.
  int         m_t;
  int         m_lvl[8];
  int         m_tgt[8];
  bit         m_fading;
  bit         m_pend_v;
  logic [7:0] m_pend;
  logic [7:0] m_led;

  led_fader #(
    .PWM_BITS(3),
    .PERIODS_PER_STEP(PER)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pat_valid(pat_valid),
    .pat_data (pat_data),
    .pat_ready(pat_ready),
    .led      (led),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_targets(input logic [7:0] p);
    for (int i = 0; i < 8; i++) m_tgt[i] = p[i] ? MAXL : 0;
  endtask

  function automatic bit model_done();
    for (int i = 0; i < 8; i++) if (m_lvl[i] != m_tgt[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance model and DUT by one clock, then compare all outputs.
  task automatic step();
    int pwm;
    bit tick, xfer, done;
    logic [7:0] nled;
    if (!rst_n) begin
      m_t = 0; m_fading = 0; m_pend_v = 0; m_pend = '0; m_led = '0;
      for (int i = 0; i < 8; i++) begin m_lvl[i] = 0; m_tgt[i] = 0; end
    end else begin
      pwm  = m_t % MAXL;
      tick = (m_t % (MAXL * PER)) == (MAXL * PER - 1);
      xfer = pat_valid && !m_pend_v;
      done = model_done();
      for (int i = 0; i < 8; i++) nled[i] = (m_lvl[i] > pwm);
      if (m_fading && tick)
        for (int i = 0; i < 8; i++)
          if (m_lvl[i] < m_tgt[i]) m_lvl[i]++;
          else if (m_lvl[i] > m_tgt[i]) m_lvl[i]--;
      if (!m_fading) begin
        if (xfer) begin set_targets(pat_data); m_fading = 1; end
      end else if (done) begin
        if (m_pend_v) begin set_targets(m_pend); m_pend_v = 0; end
        else if (xfer) set_targets(pat_data);
        else m_fading = 0;
      end else if (xfer) begin
        m_pend = pat_data; m_pend_v = 1;
      end
      m_led = nled;
      m_t = (m_t + 1) % (MAXL * PER);
    end
    @(posedge clk);
    #1;
    chk("led", led, m_led);
    chk("pat_ready", {7'd0, pat_ready}, {7'd0, !m_pend_v});
    chk("busy", {7'd0, busy}, {7'd0, m_fading || m_pend_v});
  endtask

  task automatic send(input logic [7:0] p, input int bound);
    bit done_x = 0;
    int n = 0;
    pat_valid = 1'b1;
    pat_data  = p;
    while (!done_x && n < bound) begin
      done_x = !m_pend_v;
      step();
      n++;
    end
    pat_valid = 1'b0;
    chk("send_accepted", {7'd0, done_x}, 8'h01);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_fading || m_pend_v) && n < bound) begin step(); n++; end
    chk("wait_idle", {7'd0, busy}, 8'h00);
  endtask

  // Count high cycles per LED over one PWM period and compare with the steady pattern.
  task automatic check_duty(input string tag, input logic [7:0] p);
    int cnt[8];
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int c = 0; c < MAXL; c++) begin
      step();
      for (int i = 0; i < 8; i++) cnt[i] += int'(led[i]);
    end
    for (int i = 0; i < 8; i++) chk(tag, 8'(cnt[i]), p[i] ? 8'd7 : 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] p;
    rst_n = 1'b0; pat_valid = 1'b0; pat_data = '0;
    do_reset();
    chk("reset_led", led, 8'h00);
    chk("reset_ready", {7'd0, pat_ready}, 8'h01);
    chk("reset_busy", {7'd0, busy}, 8'h00);

    // Full fade up from reset.
    send(8'hFF, 4);
    chk("busy_after_xfer", {7'd0, busy}, 8'h01);
    wait_idle(200);
    check_duty("duty_ff", 8'hFF);

    // Cross-fade with a pattern queued mid-fade.
    do_reset();
    send(8'h0F, 4);
    repeat (20) step();
    send(8'hF0, 4);
    chk("pending_ready_low", {7'd0, pat_ready}, 8'h00);
    n = 0;
    while (m_pend_v && n < 300) begin step(); n++; end
    chk("pending_consumed_ready", {7'd0, pat_ready}, 8'h01);
    wait_idle(200);
    check_duty("duty_f0", 8'hF0);

    // Same pattern again: one busy cycle, duty unchanged.
    send(8'h55, 4);
    wait_idle(200);
    send(8'hAA, 4);
    wait_idle(200);
    send(8'hAA, 4);
    chk("same_pat_busy", {7'd0, busy}, 8'h01);
    step();
    chk("same_pat_idle", {7'd0, busy}, 8'h00);
    check_duty("duty_aa", 8'hAA);

    // pat_valid arrives exactly on the completion cycle.
    send(8'h01, 4);
    n = 0;
    while (!(m_fading && model_done()) && n < 300) begin step(); n++; end
    pat_valid = 1'b1; pat_data = 8'h80;
    step();
    pat_valid = 1'b0;
    chk("direct_load_busy", {7'd0, busy}, 8'h01);
    chk("direct_load_ready", {7'd0, pat_ready}, 8'h01);
    wait_idle(200);
    check_duty("duty_80", 8'h80);

    // Reset while fading with a pattern pending.
    send(8'hFF, 4);
    repeat (30) step();
    send(8'h00, 4);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midreset_led", led, 8'h00);
    chk("midreset_ready", {7'd0, pat_ready}, 8'h01);
    chk("midreset_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    check_duty("midreset_dark", 8'h00);

    // Randomized pattern stream with random gaps.
    for (int k = 0; k < 20; k++) begin
      p = 8'($urandom);
      send(p, 400);
      n = int'($urandom_range(0, 60));
      repeat (n) step();
    end
    wait_idle(1000);
    check_duty("duty_last", p);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
